// File: rtl/tone_seq_pkg.sv
// Shared types and sizing constants for the tone sequencer and its note memory.
package tone_seq_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_TONE = 2'd1,
        S_GAP  = 2'd2,
        S_DONE = 2'd3
    } state_e;

    localparam int MAX_LEN = 32;
    localparam int ADDR_W  = 5;
    localparam int NOTE_W  = 3;
    localparam int TIMER_W = 24;

endpackage

// File: rtl/note_ram.sv
// 32 x 3-bit note store: synchronous write, asynchronous read.
module note_ram
    import tone_seq_pkg::*;
(
    input  logic              clk,
    input  logic              i_wr_en,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [NOTE_W-1:0] i_wr_data,
    input  logic [ADDR_W-1:0] i_rd_addr,
    output logic [NOTE_W-1:0] o_rd_data
);

    logic [NOTE_W-1:0] r_mem [MAX_LEN];

    // NOTE: no reset on the array; stored melodies must survive a reset pulse.
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/tone_sequencer.sv
// Plays a stored melody: each note sounds for TONE_CYCLES, followed by GAP_CYCLES of silence.
module tone_sequencer
    import tone_seq_pkg::*;
#(
    parameter int TONE_CYCLES = 12500000,
    parameter int GAP_CYCLES  = 2500000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [NOTE_W-1:0] wr_note,
    input  logic [5:0]        seq_len,
    input  logic              start,
    input  logic              abort,
    output logic [NOTE_W-1:0] note,
    output logic              en,
    output logic              busy,
    output logic [ADDR_W-1:0] step,
    output logic              done
);

    localparam logic [TIMER_W-1:0] TONE_LOAD = TIMER_W'(TONE_CYCLES - 1);
    localparam logic [TIMER_W-1:0] GAP_LOAD  = TIMER_W'(GAP_CYCLES - 1);

    state_e              r_state, w_state_next;
    logic [TIMER_W-1:0]  r_timer, w_timer_next;
    logic [ADDR_W-1:0]   r_step,  w_step_next;
    logic [ADDR_W-1:0]   r_last;
    logic                r_len_zero;
    logic                r_start;
    logic [NOTE_W-1:0]   r_note,  w_note_next;
    logic                r_en, r_busy, r_done;
    logic [NOTE_W-1:0]   w_rd_data;
    logic                w_start_ok;

    // Start is captured one cycle ahead of the FSM, so a same-cycle write lands before the first read.
    assign w_start_ok = start && !abort && (r_state == S_IDLE);

    note_ram u_note_ram (
        .clk       (clk),
        .i_wr_en   (wr_en && (r_state == S_IDLE)),
        .i_wr_addr (wr_addr),
        .i_wr_data (wr_note),
        .i_rd_addr (w_step_next),
        .o_rd_data (w_rd_data)
    );

    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latches).
    always_comb begin
        w_state_next = r_state;
        w_timer_next = r_timer;
        w_step_next  = r_step;
        case (r_state)
            S_IDLE: begin
                if (r_start && !abort) begin
                    w_step_next = '0;
                    if (r_len_zero) begin
                        w_state_next = S_DONE;
                        w_timer_next = '0;
                    end else begin
                        w_state_next = S_TONE;
                        w_timer_next = TONE_LOAD;
                    end
                end
            end
            S_TONE: begin
                if (abort) begin
                    w_state_next = S_IDLE;
                    w_step_next  = '0;
                    w_timer_next = '0;
                end else if (r_timer == '0) begin
                    w_state_next = S_GAP;
                    w_timer_next = GAP_LOAD;
                end else begin
                    w_timer_next = r_timer - 1'b1;
                end
            end
            S_GAP: begin
                if (abort) begin
                    w_state_next = S_IDLE;
                    w_step_next  = '0;
                    w_timer_next = '0;
                end else if (r_timer == '0) begin
                    if (r_step == r_last) begin
                        w_state_next = S_DONE;
                        w_timer_next = '0;
                    end else begin
                        w_state_next = S_TONE;
                        w_step_next  = r_step + 1'b1;
                        w_timer_next = TONE_LOAD;
                    end
                end else begin
                    w_timer_next = r_timer - 1'b1;
                end
            end
            S_DONE: begin
                w_state_next = S_IDLE;
                w_step_next  = '0;
                w_timer_next = '0;
            end
            default: begin
                w_state_next = S_IDLE;
                w_step_next  = '0;
                w_timer_next = '0;
            end
        endcase

        case (w_state_next)
            S_TONE:  w_note_next = w_rd_data;
            S_GAP:   w_note_next = r_note;
            default: w_note_next = '0;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_timer    <= '0;
            r_step     <= '0;
            r_last     <= '0;
            r_len_zero <= 1'b0;
            r_start    <= 1'b0;
            r_note     <= '0;
            r_en       <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_timer <= w_timer_next;
            r_step  <= w_step_next;
            r_start <= w_start_ok;
            if (w_start_ok) begin
                r_len_zero <= (seq_len == '0);
                r_last     <= (seq_len >= 6'(MAX_LEN)) ? ADDR_W'(MAX_LEN - 1)
                                                       : ADDR_W'(seq_len - 6'd1);
            end
            r_note <= w_note_next;
            r_en   <= (w_state_next == S_TONE);
            r_busy <= (w_state_next == S_TONE) || (w_state_next == S_GAP);
            r_done <= (w_state_next == S_DONE);
        end
    end

    assign note = r_note;
    assign en   = r_en;
    assign busy = r_busy;
    assign step = r_step;
    assign done = r_done;

endmodule

// File: tb/tb_tone_sequencer.sv
// Directed bench for tone_sequencer with TONE_CYCLES=4, GAP_CYCLES=2 (6-cycle note period).
module tb_tone_sequencer;

    localparam int TC = 4;
    localparam int GC = 2;
    localparam int P  = TC + GC;

    logic       clk = 1'b0;
    logic       reset;
    logic       wr_en;
    logic [4:0] wr_addr;
    logic [2:0] wr_note;
    logic [5:0] seq_len;
    logic       start;
    logic       abort;
    logic [2:0] note;
    logic       en;
    logic       busy;
    logic [4:0] step;
    logic       done;

    int checks = 0;
    int errors = 0;

    logic [2:0] model_mem [32];

    tone_sequencer #(.TONE_CYCLES(TC), .GAP_CYCLES(GC)) dut (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_note (wr_note),
        .seq_len (seq_len),
        .start   (start),
        .abort   (abort),
        .note    (note),
        .en      (en),
        .busy    (busy),
        .step    (step),
        .done    (done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [10:0] obs, input logic [10:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp_v);
        end
    endtask

    function automatic logic [10:0] outs();
        return {en, busy, done, note, step};
    endfunction

    // Play a melody of seq_in notes from edge 0; optionally poke start + write to slot 1 mid-run.
    task automatic play(input int seq_in, input int poke_cyc);
        int len;
        int k;
        int ph;
        logic [10:0] exp_v;
        len = (seq_in > 32) ? 32 : seq_in;
        seq_len = 6'(seq_in);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c <= len * P + 2; c++) begin
            tick();
            if (c <= len * P) begin
                k  = (c - 1) / P;
                ph = (c - 1) % P;
                exp_v = {(ph < TC), 1'b1, 1'b0, model_mem[k], 5'(k)};
                check($sformatf("play%0d_c%0d", seq_in, c), outs(), exp_v);
            end else if (c == len * P + 1) begin
                check($sformatf("play%0d_done_c%0d", seq_in, c), {8'd0, en, busy, done}, 11'b001);
            end else begin
                check($sformatf("play%0d_idle_c%0d", seq_in, c), outs(), 11'd0);
            end
            if (poke_cyc > 0 && (c == poke_cyc || c == poke_cyc + P)) begin
                start   = 1'b1;
                wr_en   = 1'b1;
                wr_addr = 5'd1;
                wr_note = 3'd7;
            end else begin
                start = 1'b0;
                wr_en = 1'b0;
            end
        end
    endtask

    initial begin
        reset   = 1'b1;
        wr_en   = 1'b0;
        wr_addr = '0;
        wr_note = '0;
        seq_len = '0;
        start   = 1'b0;
        abort   = 1'b0;
        #3;
        check("reset_state", outs(), 11'd0);
        tick();
        tick();
        reset = 1'b0;

        for (int i = 0; i < 32; i++) begin
            case (i)
                0:       model_mem[i] = 3'd3;
                1:       model_mem[i] = 3'd5;
                2:       model_mem[i] = 3'd1;
                default: model_mem[i] = 3'((i * 5 + 2) % 8);
            endcase
            wr_en   = 1'b1;
            wr_addr = 5'(i);
            wr_note = model_mem[i];
            tick();
        end
        wr_en = 1'b0;
        check("idle_after_load", outs(), 11'd0);

        // Basic three-note melody: done in cycle 19, idle in cycle 20.
        play(3, -1);

        // Zero-length request: done in cycle 1, never busy.
        seq_len = 6'd0;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        check("len0_done_c1", outs(), {3'b001, 3'd0, 5'd0});
        tick();
        check("len0_idle_c2", outs(), 11'd0);

        // Start/write pokes during playback are ignored, now and in the next run.
        play(3, 3);
        play(3, -1);

        // Abort during the second tone.
        seq_len = 6'd3;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            tick();
            check($sformatf("abort_run_c%0d", c), {en, busy, note},
                  {((c - 1) % P < TC), 1'b1, model_mem[(c - 1) / P]});
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_c9", outs(), 11'd0);
        for (int c = 10; c <= 24; c++) begin
            tick();
            check($sformatf("abort_quiet_c%0d", c), {8'd0, en, busy, done}, 11'd0);
        end

        // Abort together with start in IDLE: stays idle.
        seq_len = 6'd3;
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        tick();
        check("abort_start_c1", outs(), 11'd0);
        tick();
        check("abort_start_c2", outs(), 11'd0);

        // Asynchronous reset in cycle 3 mid-tone.
        seq_len = 6'd3;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
        check("pre_reset_c3", {en, busy, note, step}, {1'b1, 1'b1, 3'd3, 5'd0});
        #2;
        reset = 1'b1;
        #1;
        check("async_reset", outs(), 11'd0);
        tick();
        check("reset_held", outs(), 11'd0);
        reset = 1'b0;
        play(3, -1);

        // Oversized request clamps to 32 notes; done in cycle 193.
        play(40, -1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
